// File: rtl/crc32_engine_pkg.sv
// POLI_types_pkg: shared types and constants for the CRC-32 engine.
//   WORD_SIZE   - datapath width in bits (32)
//   CRC32_POLY  - reflected IEEE CRC-32 polynomial
//   CRC32_INIT  - accumulator preset value
//   crc_state_t - engine FSM states {IDLE, BUSY}
package POLI_types_pkg;

  localparam int unsigned WORD_SIZE = 32;

  localparam logic [WORD_SIZE-1:0] CRC32_POLY = 32'hEDB88320;
  localparam logic [WORD_SIZE-1:0] CRC32_INIT = 32'hFFFFFFFF;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } crc_state_t;

endpackage

// File: rtl/crc32_engine_step.sv
// crc32_step: one combinational bit-step of a reflected CRC-32 LFSR.
// Ports:
//   acc     - current accumulator
//   d       - data bit being absorbed
//   o       - feedback inversion bit for this position
//   acc_nxt - accumulator after absorbing the bit
module crc32_step
  import POLI_types_pkg::*;
#(
  parameter logic [WORD_SIZE-1:0] POLY = CRC32_POLY
) (
  input  logic [WORD_SIZE-1:0] acc,
  input  logic                 d,
  input  logic                 o,
  output logic [WORD_SIZE-1:0] acc_nxt
);

  logic fb;

  always_comb begin
    fb      = acc[0] ^ d ^ o;
    acc_nxt = (acc >> 1) ^ (fb ? POLY : '0);
  end

endmodule

// File: rtl/crc32_engine.sv
// crc32_engine: word-at-a-time CRC-32 accumulator, bit-serial internally.
// A start in IDLE captures one data/orient word; BUSY then absorbs it LSB
// first and publishes ~acc on crc_out when the last bit is processed.
// Successive words chain from the current accumulator.
// Ports:
//   CLK         - clock, rising edge
//   nRST        - synchronous active-low reset (highest priority)
//   crc_data_in - word to absorb
//   crc_orient  - per-bit feedback inversion mask
//   crc_start   - absorb one word (accepted only in IDLE)
//   crc_reset   - clear accumulator to INIT and abort (beats crc_start)
//   crc_out     - finalised CRC (~accumulator), held during BUSY
//   crc_ready   - engine idle, crc_out valid
// Build option: define CRC32_NIBBLE_EN to absorb four bits per cycle
// (8-cycle latency instead of 32; identical results).
module crc32_engine
  import POLI_types_pkg::*;
#(
  parameter logic [WORD_SIZE-1:0] POLY = CRC32_POLY,
  parameter logic [WORD_SIZE-1:0] INIT = CRC32_INIT
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [WORD_SIZE-1:0] crc_data_in,
  input  logic [WORD_SIZE-1:0] crc_orient,
  input  logic                 crc_start,
  input  logic                 crc_reset,
  output logic [WORD_SIZE-1:0] crc_out,
  output logic                 crc_ready
);

`ifdef CRC32_NIBBLE_EN
  localparam int unsigned STEPS = 4;
`else
  localparam int unsigned STEPS = 1;
`endif

  crc_state_t           state_q, state_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] acc_q, acc_d;
  logic [WORD_SIZE-1:0] dreg_q, dreg_d;
  logic [WORD_SIZE-1:0] oreg_q, oreg_d;
  logic [WORD_SIZE-1:0] out_q, out_d;

  // chain[0] is the current accumulator; chain[STEPS] is after this cycle's bits.
  logic [STEPS:0][WORD_SIZE-1:0] chain;
  logic                          last_step;

  assign chain[0] = acc_q;

  for (genvar g = 0; g < STEPS; g++) begin : g_step
    logic [4:0] idx;
    assign idx = cnt_q + 5'(g);

    crc32_step #(
      .POLY(POLY)
    ) u_step (
      .acc    (chain[g]),
      .d      (dreg_q[idx]),
      .o      (oreg_q[idx]),
      .acc_nxt(chain[g+1])
    );
  end

  // The final group starts at bit 32-STEPS; cnt then wraps to 0 as we go IDLE.
  assign last_step = (cnt_q == 5'(WORD_SIZE - STEPS));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    dreg_d  = dreg_q;
    oreg_d  = oreg_q;
    out_d   = out_q;

    if (crc_reset) begin
      state_d = IDLE;
      acc_d   = INIT;
      out_d   = ~INIT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (crc_start) begin
            dreg_d  = crc_data_in;
            oreg_d  = crc_orient;
            cnt_d   = '0;
            state_d = BUSY;
          end
        end
        BUSY: begin
          acc_d = chain[STEPS];
          cnt_d = cnt_q + 5'(STEPS);
          if (last_step) begin
            state_d = IDLE;
            out_d   = ~chain[STEPS];
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= INIT;
      dreg_q  <= '0;
      oreg_q  <= '0;
      out_q   <= ~INIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      dreg_q  <= dreg_d;
      oreg_q  <= oreg_d;
      out_q   <= out_d;
    end
  end

  assign crc_out   = out_q;
  assign crc_ready = (state_q == IDLE);

endmodule

// File: tb/tb_crc32_engine.sv
// Self-checking bench for crc32_engine: directed vector table, multi-cycle
// corner sequences (abort, held start, reset priority) and a chained random
// comparison against a bit-serial reference model.
// Build option: CRC32_NIBBLE_EN selects the 8-cycle latency expectation.
module tb_crc32_engine;

`ifdef CRC32_NIBBLE_EN
  localparam int unsigned LAT = 8;
`else
  localparam int unsigned LAT = 32;
`endif
  localparam int unsigned ABORT_AT = (LAT > 10) ? 10 : 4;
  localparam int unsigned HOLD     = LAT + 8;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] crc_data_in;
  logic [31:0] crc_orient;
  logic        crc_start;
  logic        crc_reset;
  logic [31:0] crc_out;
  logic        crc_ready;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 CLK = ~CLK;

  crc32_engine #(
    .POLY(32'hEDB88320),
    .INIT(32'hFFFFFFFF)
  ) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .crc_data_in(crc_data_in),
    .crc_orient (crc_orient),
    .crc_start  (crc_start),
    .crc_reset  (crc_reset),
    .crc_out    (crc_out),
    .crc_ready  (crc_ready)
  );

  typedef struct {
    logic        clr;
    logic [31:0] data;
    logic [31:0] orient;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[5];

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int unsigned got, input int unsigned exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference: absorb one word bit-serially, LSB first.
  function automatic logic [31:0] model_word(input logic [31:0] acc, input logic [31:0] d,
                                             input logic [31:0] o);
    logic [31:0] a;
    logic        fb;
    a = acc;
    for (int k = 0; k < 32; k++) begin
      fb = a[0] ^ d[k] ^ o[k];
      a  = (a >> 1) ^ (fb ? 32'hEDB88320 : 32'h0);
    end
    return a;
  endfunction

  // Entered at a negedge with the engine idle; returns at the negedge where
  // crc_ready is seen high again.
  task automatic absorb(input logic [31:0] d, input logic [31:0] o, output logic [31:0] res,
                        output int unsigned lowcnt, output logic held);
    logic [31:0] prev;
    prev        = crc_out;
    held        = 1'b1;
    crc_data_in = d;
    crc_orient  = o;
    crc_start   = 1'b1;
    @(negedge CLK);
    crc_start = 1'b0;
    lowcnt    = 0;
    while (!crc_ready && lowcnt < 200) begin
      if (crc_out !== prev) held = 1'b0;
      lowcnt++;
      @(negedge CLK);
    end
    res = crc_out;
  endtask

  task automatic pulse_clear();
    crc_reset = 1'b1;
    @(negedge CLK);
    crc_reset = 1'b0;
  endtask

  logic [31:0] res;
  int unsigned lowcnt;
  logic        held;
  logic [31:0] macc;
  int unsigned ready_hits;
  int unsigned ready_idx;

  initial begin
    vecs[0] = '{clr: 1'b1, data: 32'h0000_0000, orient: 32'h0000_0000, exp: 32'h2144DF1C};
    vecs[1] = '{clr: 1'b0, data: 32'h0000_0000, orient: 32'h0000_0000, exp: 32'h6522DF69};
    vecs[2] = '{clr: 1'b1, data: 32'hFFFF_FFFF, orient: 32'h0000_0000, exp: 32'hFFFFFFFF};
    vecs[3] = '{clr: 1'b1, data: 32'h0000_0000, orient: 32'hFFFF_FFFF, exp: 32'hFFFFFFFF};
    vecs[4] = '{clr: 1'b1, data: 32'hFFFF_FFFF, orient: 32'hFFFF_FFFF, exp: 32'h2144DF1C};

    nRST        = 1'b0;
    crc_data_in = '0;
    crc_orient  = '0;
    crc_start   = 1'b0;
    crc_reset   = 1'b0;

    // Reset state
    @(negedge CLK);
    @(negedge CLK);
    check32("reset_out", crc_out, 32'h0);
    check_int("reset_ready", int'(crc_ready), 1);
    nRST = 1'b1;
    @(negedge CLK);

    // Directed vectors
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].clr) pulse_clear();
      absorb(vecs[i].data, vecs[i].orient, res, lowcnt, held);
      check32($sformatf("vec%0d_crc", i), res, vecs[i].exp);
      check_int($sformatf("vec%0d_latency", i), lowcnt, LAT);
      check_int($sformatf("vec%0d_held", i), int'(held), 1);
    end

    // crc_reset part-way through BUSY aborts the word
    absorb(32'h0, 32'h0, res, lowcnt, held);  // crc_out now 6522DF69, non-zero
    crc_data_in = 32'h0;
    crc_orient  = 32'h0;
    crc_start   = 1'b1;
    @(negedge CLK);
    crc_start = 1'b0;
    for (int i = 1; i < ABORT_AT; i++) @(negedge CLK);
    crc_reset = 1'b1;
    @(negedge CLK);
    crc_reset = 1'b0;
    check_int("abort_ready", int'(crc_ready), 1);
    check32("abort_out", crc_out, 32'h0);
    absorb(32'h0, 32'h0, res, lowcnt, held);
    check32("after_abort_crc", res, 32'h2144DF1C);

    // crc_start held: one absorption, then re-accepted on the first IDLE cycle
    pulse_clear();
    crc_data_in = 32'h0;
    crc_orient  = 32'h0;
    crc_start   = 1'b1;
    ready_hits  = 0;
    ready_idx   = 0;
    for (int i = 0; i < HOLD; i++) begin
      @(negedge CLK);
      if (crc_ready) begin
        ready_hits++;
        ready_idx = i;
        check32("held_first_crc", crc_out, 32'h2144DF1C);
      end
    end
    crc_start = 1'b0;
    check_int("held_ready_hits", ready_hits, 1);
    check_int("held_ready_idx", ready_idx, LAT);
    lowcnt = 0;
    while (!crc_ready && lowcnt < 200) begin
      lowcnt++;
      @(negedge CLK);
    end
    check32("held_second_crc", crc_out, 32'h6522DF69);

    // crc_start together with crc_reset: reset wins, start dropped
    crc_start = 1'b1;
    crc_reset = 1'b1;
    @(negedge CLK);
    crc_start = 1'b0;
    crc_reset = 1'b0;
    check32("startreset_out", crc_out, 32'h0);
    check_int("startreset_ready", int'(crc_ready), 1);
    @(negedge CLK);
    check_int("startreset_dropped", int'(crc_ready), 1);

    // nRST mid-BUSY aborts; nRST beats a simultaneous start
    absorb(32'hFFFF_FFFF, 32'h0, res, lowcnt, held);  // crc_out FFFFFFFF
    crc_start = 1'b1;
    @(negedge CLK);
    crc_start = 1'b0;
    repeat (3) @(negedge CLK);
    nRST      = 1'b0;
    crc_start = 1'b1;
    @(negedge CLK);
    nRST      = 1'b1;
    crc_start = 1'b0;
    check32("nrst_busy_out", crc_out, 32'h0);
    check_int("nrst_busy_ready", int'(crc_ready), 1);
    @(negedge CLK);
    check_int("nrst_start_dropped", int'(crc_ready), 1);
    absorb(32'h0, 32'h0, res, lowcnt, held);
    check32("after_nrst_crc", res, 32'h2144DF1C);

    // Chained random words against the bit-serial model
    pulse_clear();
    macc = 32'hFFFF_FFFF;
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] d;
      logic [31:0] o;
      if ($urandom_range(15) == 0) begin
        pulse_clear();
        macc = 32'hFFFF_FFFF;
      end
      d = $urandom();
      o = ($urandom_range(3) == 0) ? 32'h0 : $urandom();
      absorb(d, o, res, lowcnt, held);
      macc = model_word(macc, d, o);
      check32($sformatf("rand%0d_crc", i), res, ~macc);
      if (lowcnt != LAT) check_int($sformatf("rand%0d_latency", i), lowcnt, LAT);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
